// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: execute/write-back controller around an 8x8 register file (r0 reads as 0).
// Defining RF_EXEC_MUL_EN adds the MUL_IT-cycle unsigned shift-add multiply for op 110.
module rf_exec_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int MUL_IT = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    input  logic [DW-1:0] instr_imm,
    output logic [AW-1:0] RX,
    output logic [AW-1:0] RY,
    input  logic [DW-1:0] busX,
    input  logic [DW-1:0] busY,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          ovf,
    output logic          err
);

    localparam int SW = $clog2(DW);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000, OP_SUB  = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_SLT  = 3'b100, OP_ADDI = 3'b101, OP_MUL = 3'b110, OP_SRL = 3'b111
    } op_e;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_e;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          ready_q, ready_d, wen_q, wen_d, done_q, done_d;
    logic          ovf_q, ovf_d, err_q, err_d;
    logic [AW-1:0] rd_q, rd_d, rx_q, rx_d, ry_q, ry_d, rw_q, rw_d;
    logic [DW-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d;
    logic [DW-1:0] busw_q, busw_d, result_q, result_d;

    logic [DW-1:0] add_b, sum, diff, alu_res, fin_res;
    logic          alu_ovf, alu_err, fin, fin_ovf, fin_err;

`ifdef RF_EXEC_MUL_EN
    localparam int            CW       = $clog2(MUL_IT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_IT - 1);

    logic [2*DW-1:0] prod_q, prod_d, prod_step;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign prod_step = prod_q + (b_q[cnt_q] ? ({{DW{1'b0}}, a_q} << cnt_q) : '0);
`endif

    // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
    always_comb begin
        add_b   = (op_q == OP_ADDI) ? imm_q : b_q;
        sum     = a_q + add_b;
        diff    = a_q - b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                alu_res = sum;
                alu_ovf = (a_q[DW-1] == add_b[DW-1]) && (sum[DW-1] != a_q[DW-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[DW-1] != b_q[DW-1]) && (diff[DW-1] != a_q[DW-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SRL:  alu_res = a_q >> b_q[SW-1:0];
            default: alu_err = 1'b1;  // MUL reaching EXEC means no multiplier is built
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        a_d      = a_q;
        b_d      = b_q;
        wen_d    = 1'b0;
        done_d   = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        fin      = 1'b0;
        fin_res  = alu_res;
        fin_ovf  = alu_ovf;
        fin_err  = alu_err;
`ifdef RF_EXEC_MUL_EN
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    ready_d = 1'b0;
                    op_d    = op_e'(instr_op);
                    rd_d    = instr_rd;
                    imm_d   = instr_imm;
                    rx_d    = instr_rs;
                    ry_d    = instr_rt;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = busX;
                b_d     = busY;
                state_d = S_EXEC;
`ifdef RF_EXEC_MUL_EN
                prod_d  = '0;
                cnt_d   = '0;
                if (op_q == OP_MUL) state_d = S_MUL;
`endif
            end
            S_EXEC: fin = 1'b1;
`ifdef RF_EXEC_MUL_EN
            S_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    fin_res = prod_step[DW-1:0];
                    fin_ovf = |prod_step[2*DW-1:DW];
                    fin_err = 1'b0;
                end
            end
`endif
            S_WB: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d  = S_WB;
            result_d = fin_res;
            ovf_d    = fin_ovf;
            err_d    = fin_err;
            rw_d     = rd_q;
            busw_d   = fin_res;
            wen_d    = (rd_q != '0) && !fin_err;
            done_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            rx_q     <= '0;
            ry_q     <= '0;
            wen_q    <= 1'b0;
            done_q   <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            wen_q    <= wen_d;
            done_q   <= done_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // NOTE: operand/datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge Clk) begin
        op_q  <= op_d;
        rd_q  <= rd_d;
        imm_q <= imm_d;
        a_q   <= a_d;
        b_q   <= b_d;
`ifdef RF_EXEC_MUL_EN
        prod_q <= prod_d;
        cnt_q  <= cnt_d;
`endif
    end

    // Rst_n gating keeps an instruction aborted in WB from writing on the reset edge.
    assign WEN         = wen_q & Rst_n;
    assign instr_ready = ready_q;
    assign RX          = rx_q;
    assign RY          = ry_q;
    assign RW          = rw_q;
    assign busW        = busw_q;
    assign done        = done_q;
    assign result      = result_q;
    assign ovf         = ovf_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Self-checking bench for rf_exec_ctrl: register-file stand-in, arithmetic reference model,
// per-cycle compare and directed instruction sequence (honours RF_EXEC_MUL_EN).
module tb_rf_exec_ctrl;

    localparam int DW = 8, AW = 3, MUL_IT = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           SLT = 3'd4, ADDI = 3'd5, MUL = 3'd6, SRL = 3'd7;

    logic Clk = 1'b0;
    logic Rst_n, instr_valid, instr_ready, WEN, done, ovf, err;
    logic [2:0] instr_op;
    logic [AW-1:0] instr_rd, instr_rs, instr_rt, RX, RY, RW;
    logic [DW-1:0] instr_imm, busX, busY, busW, result;

    always #5 Clk = ~Clk;

    rf_exec_ctrl #(.DW(DW), .AW(AW), .MUL_IT(MUL_IT)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_imm(instr_imm), .RX(RX), .RY(RY), .busX(busX), .busY(busY), .WEN(WEN),
        .RW(RW), .busW(busW), .done(done), .result(result), .ovf(ovf), .err(err)
    );

    // Register file stand-in: r0 hardwired to zero, written at the end of a WEN cycle.
    logic [7:0] tb_rf [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    assign busX = (RX == 3'd0) ? 8'h00 : tb_rf[RX];
    assign busY = (RY == 3'd0) ? 8'h00 : tb_rf[RY];
    always @(posedge Clk) if (WEN && RW != 3'd0) tb_rf[RW] <= busW;

    int n_checks = 0, n_errs = 0;
    int cyc = 0, acc_cyc = 0, n_done = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (instr_valid && instr_ready) acc_cyc <= cyc;
        if (done) n_done <= n_done + 1;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
        logic       err;
        logic [7:0] lat;
    } mres_t;

    function automatic mres_t exec_model(input logic [2:0] op, input logic [7:0] a, b, imm);
        mres_t r;
        int sa, sb, si, s, p;
        sa = $signed(a);
        sb = $signed(b);
        si = $signed(imm);
        r = '0;
        r.lat = 8'd3;
        case (op)
            ADD:  begin s = sa + sb; r.res = 8'(s); r.ovf = (s > 127) || (s < -128); end
            SUB:  begin s = sa - sb; r.res = 8'(s); r.ovf = (s > 127) || (s < -128); end
            ADDI: begin s = sa + si; r.res = 8'(s); r.ovf = (s > 127) || (s < -128); end
            AND_: r.res = a & b;
            OR_:  r.res = a | b;
            SLT:  r.res = (sa < sb) ? 8'd1 : 8'd0;
            SRL:  r.res = a >> (b % 8);
            default: begin
`ifdef RF_EXEC_MUL_EN
                p = int'(a) * int'(b);
                r.res = 8'(p);
                r.ovf = (p > 255);
                r.lat = 8'(2 + MUL_IT);
`else
                r.err = 1'b1;
`endif
            end
        endcase
        return r;
    endfunction

    logic [7:0] mrf [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    mres_t acc_r, p;
    logic [2:0] p_rd, m_rx, m_ry, m_rw;
    logic [7:0] m_result, m_busw;
    logic m_ready, m_done, m_wen, m_ovf, m_err;
    int m_left = 0;

    always_comb acc_r = exec_model(instr_op, mrf[instr_rs], mrf[instr_rt], instr_imm);

    always @(posedge Clk) begin
        if (m_done && m_wen && Rst_n) mrf[m_rw] <= m_busw;
        if (!Rst_n) begin
            m_left <= 0; m_ready <= 1'b0; m_done <= 1'b0; m_wen <= 1'b0;
            m_rx <= '0; m_ry <= '0; m_rw <= '0; m_busw <= '0;
            m_result <= '0; m_ovf <= 1'b0; m_err <= 1'b0;
        end else if (m_ready && instr_valid) begin
            p <= acc_r; p_rd <= instr_rd; m_rx <= instr_rs; m_ry <= instr_rt;
            m_left <= int'(acc_r.lat); m_ready <= 1'b0; m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_ready <= (m_left == 1);
            m_done  <= (m_left == 2);
            if (m_left == 2) begin
                m_result <= p.res; m_ovf <= p.ovf; m_err <= p.err;
                m_rw <= p_rd; m_busw <= p.res; m_wen <= (p_rd != 3'd0) && !p.err;
            end
        end else begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
        end
    end

    always @(posedge Clk) begin
        #1;
        if (chk_on) begin
            check("cyc_ready",  32'(instr_ready), 32'(m_ready));
            check("cyc_done",   32'(done),        32'(m_done));
            check("cyc_wen",    32'(WEN),         32'(m_done && m_wen && Rst_n));
            check("cyc_rx",     32'(RX),          32'(m_rx));
            check("cyc_ry",     32'(RY),          32'(m_ry));
            check("cyc_rw",     32'(RW),          32'(m_rw));
            check("cyc_busw",   32'(busW),        32'(m_busw));
            check("cyc_result", 32'(result),      32'(m_result));
            check("cyc_ovf",    32'(ovf),         32'(m_ovf));
            check("cyc_err",    32'(err),         32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("accept_timeout", 32'(instr_ready), 32'd1);
        @(posedge Clk);
    endtask

    task automatic set_instr(input logic [2:0] op, rd, rs, rt, input logic [7:0] imm);
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
        instr_valid = 1'b1;
    endtask

    task automatic issue(input logic [2:0] op, rd, rs, rt, input logic [7:0] imm);
        @(negedge Clk);
        set_instr(op, rd, rs, rt, imm);
        wait_ready();
        @(negedge Clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!done && n < 40);
        check("done_timeout", 32'(done), 32'd1);
        lat = cyc - acc_cyc;
    endtask

    task automatic expect_done(input string name, input int e_lat, input logic [7:0] e_res,
                               input logic e_ovf, input logic e_err);
        int lat;
        wait_done(lat);
        check({name, "_lat"}, 32'(lat),    32'(e_lat));
        check({name, "_res"}, 32'(result), 32'(e_res));
        check({name, "_ovf"}, 32'(ovf),    32'(e_ovf));
        check({name, "_err"}, 32'(err),    32'(e_err));
    endtask

    task automatic run(input string name, input logic [2:0] op, rd, rs, rt, input logic [7:0] imm,
                       input int e_lat, input logic [7:0] e_res, input logic e_ovf, input logic e_err);
        issue(op, rd, rs, rt, imm);
        expect_done(name, e_lat, e_res, e_ovf, e_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_rf [8];
    logic [7:0] r6_exp;
    int d0;

    initial begin
        Rst_n = 1'b0;
        instr_valid = 1'b0;
        set_instr(ADD, 3'd0, 3'd0, 3'd0, 8'd0);
        instr_valid = 1'b0;

        // 1: reset
        repeat (2) @(negedge Clk);
        check("rst_wen",   32'(WEN),         32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_rx",    32'(RX),          32'd0);
        chk_on = 1'b1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("ready_after_release", 32'(instr_ready), 32'd1);

        // 2: basic ALU, signed overflow on ADD
        run("addi_r1", ADDI, 3'd1, 3'd0, 3'd0, 8'd100, 3, 8'd100, 1'b0, 1'b0);
        run("addi_r2", ADDI, 3'd2, 3'd0, 3'd0, 8'd50,  3, 8'd50,  1'b0, 1'b0);
        run("add_r3",  ADD,  3'd3, 3'd1, 3'd2, 8'd0,   3, 8'd150, 1'b1, 1'b0);
        run("sub_r4",  SUB,  3'd4, 3'd2, 3'd1, 8'd0,   3, 8'd206, 1'b0, 1'b0);

        // 3: rd = 0 never writes
        run("addi_r0", ADDI, 3'd0, 3'd0, 3'd0, 8'd55, 3, 8'd55, 1'b0, 1'b0);
        check("r0_wen", 32'(WEN), 32'd0);
        run("read_r0", ADDI, 3'd7, 3'd0, 3'd0, 8'd9, 3, 8'd9, 1'b0, 1'b0);

        // 4: multiply (or illegal op without the multiplier)
        run("addi_r5", ADDI, 3'd5, 3'd0, 3'd0, 8'd3, 3, 8'd3, 1'b0, 1'b0);
`ifdef RF_EXEC_MUL_EN
        run("mul_r6", MUL, 3'd6, 3'd1, 3'd5, 8'd0, 10, 8'd44, 1'b1, 1'b0);
        r6_exp = 8'd44;
`else
        run("mul_r6", MUL, 3'd6, 3'd1, 3'd5, 8'd0, 3, 8'd0, 1'b0, 1'b1);
        check("mul_off_wen", 32'(WEN), 32'd0);
        r6_exp = 8'hA5;
`endif
        @(negedge Clk);
        check("r6_after_mul", 32'(tb_rf[6]), 32'(r6_exp));

        // 5a: reset during the 4th multiply cycle
        issue(MUL, 3'd6, 3'd1, 3'd1, 8'd0);
        repeat (4) @(negedge Clk);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("abort_ready", 32'(instr_ready), 32'd0);
        check("abort_done",  32'(done),        32'd0);
        check("abort_rx",    32'(RX),          32'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("abort_ready_release", 32'(instr_ready), 32'd1);
        check("r6_after_abort", 32'(tb_rf[6]), 32'(r6_exp));

        // 5b: reset landing on the write-back edge must suppress the write
        issue(ADDI, 3'd4, 3'd0, 3'd0, 8'd77);
        expect_done("addi_wb_abort", 3, 8'd77, 1'b0, 1'b0);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("r4_after_wb_abort", 32'(tb_rf[4]), 32'd206);
        Rst_n = 1'b1;

        // 6: valid held high across a busy instruction
        @(negedge Clk);
        d0 = n_done;
        set_instr(SLT, 3'd7, 3'd4, 3'd1, 8'd0);
        wait_ready();
        @(negedge Clk);
        set_instr(OR_, 3'd5, 3'd3, 3'd2, 8'd0);
        expect_done("slt_r7", 3, 8'd1, 1'b0, 1'b0);
        wait_ready();
        @(negedge Clk);
        instr_valid = 1'b0;
        expect_done("or_r5", 3, 8'd182, 1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        check("held_done_count", 32'(n_done - d0), 32'd2);

        // shift, SUB overflow, SLT equal, ADDI negative immediate
        run("srl_r2",  SRL,  3'd2, 3'd3, 3'd5, 8'd0,   3, 8'd2,   1'b0, 1'b0);
        run("sub_ovf", SUB,  3'd3, 3'd4, 3'd1, 8'd0,   3, 8'd106, 1'b1, 1'b0);
        run("slt_eq",  SLT,  3'd7, 3'd1, 3'd1, 8'd0,   3, 8'd0,   1'b0, 1'b0);
        run("addi_neg", ADDI, 3'd1, 3'd1, 3'd0, 8'h9C, 3, 8'd0,   1'b0, 1'b0);
        repeat (3) @(negedge Clk);

        exp_rf = '{8'd0, 8'd0, 8'd2, 8'd106, 8'd206, 8'd182, r6_exp, 8'd0};
        for (int i = 0; i < 8; i++)
            check($sformatf("final_r%0d", i), 32'(tb_rf[i]), 32'(exp_rf[i]));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
